// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmit path: default sample width and
// synchroniser depth, the serialiser state encoding, and a helper that sizes
// the bit counter so it can hold the value DATA_W itself.
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int DATA_W_DEFAULT      = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // IDLE : waiting for the first left-slot start after reset
    // SHIFT: driving data bits MSB-first
    // PAD  : word finished, driving zeros until the next slot edge
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } state_t;

    // Bit counter width: must represent 0..data_w inclusive.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through a flip-flop chain
// and produces registered single-clk rise/fall strobes.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   async_in in   level from another clock domain
//   sync_out out  synchronised level (last chain stage)
//   rise     out  one-clk strobe, synchronised level went 0->1
//   fall     out  one-clk strobe, synchronised level went 1->0
//
// The strobes trail sync_out by one clk. A companion signal that changes on
// the same pad edge as this one therefore already shows its new value on
// sync_out when the strobe fires, even if it resolved one clk late.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: every register here is assigned with <= so all stages sample the
    // pre-edge values; blocking assignments would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
            rise <= chain[STAGES-1] & ~prev;
            fall <= ~chain[STAGES-1] & prev;
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
// Serialises stereo sample pairs onto an I2S data line. bclk and l_r_clk come
// from an external master and are oversampled in the clk domain; sdata is
// updated one clk after each synchronised bclk falling strobe, MSB first, one
// bclk after every word-select change. A one-entry holding buffer with a
// valid/ready handshake decouples the producer from slot timing.
//
// Ports:
//   clk          in   system clock, at least 8x bclk
//   reset        in   asynchronous active-low reset
//   bclk         in   external bit clock
//   l_r_clk      in   external word select, 0 = left slot, 1 = right slot
//   left_in      in   signed left sample
//   right_in     in   signed right sample
//   sample_valid in   producer offers left_in/right_in
//   sample_ready out  holding buffer empty
//   sdata        out  serial data, registered
//   underrun     out  one-clk pulse: left slot started with the buffer empty
// -----------------------------------------------------------------------------
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              l_r_clk,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sdata,
    output logic              underrun
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    // ---------------------------------------------------------------- sync
    logic bclk_sync, bclk_rise, bclk_fall;
    logic lr_sync, lr_rise, lr_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bclk),
        .sync_out (bclk_sync),
        .rise     (bclk_rise),
        .fall     (bclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lr_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (l_r_clk),
        .sync_out (lr_sync),
        .rise     (lr_rise),
        .fall     (lr_fall)
    );

    // Only the bclk falling strobe and the l_r_clk level are needed here.
    logic unused_sync;
    assign unused_sync = &{1'b0, bclk_sync, bclk_rise, lr_rise, lr_fall};

    // ---------------------------------------------------------- registers
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic [DATA_W-1:0]   hold_l, hold_l_nxt, hold_r, hold_r_nxt;
    logic [DATA_W-1:0]   active_l, active_l_nxt, active_r, active_r_nxt;
    logic                hold_full, hold_full_nxt;
    logic                lr_prev, lr_prev_nxt;
    logic                sdata_nxt, underrun_nxt, ready_nxt;

    logic accept;
    logic slot_edge;

    assign accept    = sample_valid && sample_ready;
    assign slot_edge = bclk_fall && (lr_sync != lr_prev);

    // ---------------------------------------------------- next-state logic
    // NOTE: every variable gets its hold value first, so no path through the
    // branches below leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shreg_nxt     = shreg;
        hold_l_nxt    = hold_l;
        hold_r_nxt    = hold_r;
        hold_full_nxt = hold_full;
        active_l_nxt  = active_l;
        active_r_nxt  = active_r;
        lr_prev_nxt   = lr_prev;
        sdata_nxt     = sdata;
        underrun_nxt  = 1'b0;

        if (accept) begin
            hold_l_nxt    = left_in;
            hold_r_nxt    = right_in;
            hold_full_nxt = 1'b1;
        end

        if (bclk_fall) begin
            lr_prev_nxt = lr_sync;

            // Drive first: the last bit of the outgoing word leaves on the
            // same fall that starts the next slot.
            if (state == SHIFT) begin
                sdata_nxt = shreg[DATA_W-1];
                shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                cnt_nxt   = cnt + 1'b1;
                if (cnt_nxt == CNT_LAST) begin
                    state_nxt = PAD;
                end
            end else begin
                sdata_nxt = 1'b0;
            end

            // Then load, overriding the shift result on a slot edge.
            if (slot_edge) begin
                if (!lr_sync) begin
                    // hold_full implies no accept this clk (ready was low),
                    // so the transfer always takes the older pair.
                    if (hold_full) begin
                        active_l_nxt  = hold_l;
                        active_r_nxt  = hold_r;
                        hold_full_nxt = 1'b0;
                        shreg_nxt     = hold_l;
                    end else begin
                        active_l_nxt  = '0;
                        active_r_nxt  = '0;
                        underrun_nxt  = 1'b1;
                        shreg_nxt     = '0;
                    end
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end else if (state != IDLE) begin
                    shreg_nxt = active_r;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
        end

        ready_nxt = !hold_full_nxt;
    end

    // NOTE: the sample buffers are reset along with the control state even
    // though hold_full/state gate their use; this keeps sdata deterministic
    // and avoids X propagation on the first frames after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            hold_full    <= 1'b0;
            active_l     <= '0;
            active_r     <= '0;
            lr_prev      <= 1'b0;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            shreg        <= shreg_nxt;
            hold_l       <= hold_l_nxt;
            hold_r       <= hold_r_nxt;
            hold_full    <= hold_full_nxt;
            active_l     <= active_l_nxt;
            active_r     <= active_r_nxt;
            lr_prev      <= lr_prev_nxt;
            sdata        <= sdata_nxt;
            underrun     <= underrun_nxt;
            sample_ready <= ready_nxt;
        end
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
Serialises processed stereo samples, such as the three-band EQ output, onto an I2S data line for the output DAC. It is the transmit end of the I2S link whose receive side produces audio_in and l_r_clk. BCLK and LRCLK are externally mastered, for example by the codec. The block oversamples both in the single system clock domain and drives SDATA MSB-first, one BCLK after each LRCLK transition. A one-entry stereo holding buffer with a valid/ready handshake decouples the producer from slot timing.

Parameters:
DATA_W, 16, sample width in bits; must be ≥ 2.
SYNC_STAGES, 2, flip-flop stages in each bclk/l_r_clk synchroniser.

Ports:
clk  input  1  high-speed system clock; must be ≥ 8× bclk frequency
reset  input  1  asynchronous, active-low reset
bclk  input  1  external I2S bit clock, asynchronous to clk
l_r_clk  input  1  external I2S word select (0 = left slot, 1 = right slot), changes on bclk falling edge
left_in  input  DATA_W  signed left sample
right_in  input  DATA_W  signed right sample
sample_valid  input  1  producer offers the left_in/right_in pair
sample_ready  output  1  holding buffer empty; pair accepted when valid && ready at a clk edge
sdata  output  1  I2S serial data, registered
underrun  output  1  one-clk pulse: left slot started with the holding buffer empty

Behaviour:
- Reset (reset = 0), asynchronous: sdata = 0, underrun = 0, sample_ready = 0, hold/active/shift registers = 0, bit count = 0, state = IDLE, synchronisers cleared.
- After reset release: sample_ready = 1 on the first clk edge, because hold is empty.
- Synchronisation: bclk and l_r_clk each pass SYNC_STAGES flip-flops.
  - fall = synced bclk 1→0 (single-clk strobe).
  - lr_prev = l_r_clk sampled at the previous fall.
  - slot_edge = fall && (synced l_r_clk != lr_prev).
- Accept: on valid && ready, hold_l/hold_r capture the inputs and hold_full is set. sample_ready = !hold_full.
- sdata update: only on fall strobes, registered, so the pin changes 1 clk after the strobe. Total lag from the pad bclk edge is SYNC_STAGES+2 clk, which is within half a bclk at ≥ 8× oversampling.
- Drive value on each fall: if state = SHIFT, sdata = shreg[DATA_W-1], shreg shifts left, cnt++, and state goes to PAD when cnt reaches DATA_W. Otherwise sdata = 0.
- Load, on slot_edge, after the drive above:
  - New l_r_clk = 0 (left slot start):
    - If hold_full: active_l/active_r ← hold and hold_full clears; sample_ready rises the next clk.
    - Else: active ← 0 and underrun pulses for 1 clk.
    - shreg ← active_l value (the newly transferred value when hold was full); cnt = 0; state = SHIFT.
  - New l_r_clk = 1 (right slot start): shreg ← active_r, cnt = 0, state = SHIFT. IDLE ignores right-slot starts.
- Resulting timing: the MSB appears on the first fall after the LRCLK change, then bits follow until the LSB. Any remaining slot bits are 0 (PAD).
- States:
  - IDLE: waits for the first left-slot start.
  - SHIFT: driving data bits.
  - PAD: driving zeros until the next slot_edge.
- Boundaries:
  - Slot exactly DATA_W bits: the LSB is driven on the same fall as the next slot_edge (drive before load), giving no gap.
  - Slot shorter than DATA_W: the word is truncated at slot_edge, LSBs are dropped, and there is no error.
  - Accept and transfer in the same clk with hold full: transfer takes the old hold contents; the new pair is not accepted because ready was 0.
  - Accept in the same clk as a left slot start with hold empty: underrun fires, zeros are sent, and the new pair lands in hold for the next frame.
  - Reset mid-word: outputs clear immediately. After release the block waits in IDLE for the next left-slot start and never emits a partial word.

Decomposition:
- i2s_pkg: DATA_W default, state enum (IDLE, SHIFT, PAD), counter width $clog2(DATA_W+1).
- Sub-module sync_edge_detect(clk, reset, async_in → sync_out, rise, fall), instantiated for bclk and l_r_clk.

Test Plan:
- Basic frame (bclk = clk/8, 32-bit slots): left_in = 16'hA5F0, right_in = 16'h0F0F, valid before the left slot. Left slot on sdata: A5F0 MSB-first from fall 1, then 16 zeros. Right slot: 0F0F then zeros. No underrun.
- Underrun: no valid for one frame. That frame sdata is all zeros, underrun pulses exactly one clk at the left slot start, and the next supplied pair plays normally.
- Backpressure: offer two pairs (1111/2222 then 3333/4444) back to back. The second stalls with sample_ready = 0 until the left-slot transfer, ready rises 1 clk later, and frames play 1111/2222 then 3333/4444.
- Startup mid-frame: release reset while l_r_clk = 1. sdata stays 0 through the right slot, and the first MSB comes one bclk after the 1→0 transition.
- Reset mid-word: pull reset low at bit 7 of a left word. sdata = 0 and sample_ready = 0 immediately. After release, output resumes only at the next left-slot start with a full word.
- 16-bit slots, alternating 8000/7FFF: continuous bitstream, the LSB coincides with the LRCLK change fall, and there are no padding bits.
